// File: rtl/fpu_pkg.sv
// Shared constants and FSM state type for the single-precision add back end.
package fpu_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int FRAC_W   = 26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/leading_one_detect.sv
// Combinational leading-one detector: index of the most significant set bit.
module leading_one_detect #(
    parameter int W     = 26,
    parameter int IDX_W = 5
) (
    input  logic [W-1:0]     i_data,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_zero
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (i_data[i]) o_idx = IDX_W'(i);
        end
    end

    assign o_zero = ~|i_data;

endmodule

// File: rtl/add_normalize_round.sv
// Normalize and round-to-nearest-even a raw adder sum into a packed float.
// Accept -> NORM -> ROUND -> DONE. out_valid is registered one cycle into DONE
// so the result appears exactly three edges after the accepting edge.
module add_normalize_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = fpu_pkg::FRAC_W
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  sign_in,
    input  logic [EXP_W-1:0]      exp_in,
    input  logic [FRAC_W:0]       frac_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W-3:0] fp_out,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  inexact
);
    import fpu_pkg::*;

    // Mantissa bits: hidden bit and two guard bits removed from the aligned fraction.
    localparam int MW    = FRAC_W - 3;
    // Two extra exponent bits give headroom for +carry and for negative results.
    localparam int XW    = EXP_W + 2;
    localparam int IDX_W = $clog2(FRAC_W);
    localparam logic signed [XW-1:0] EXP_MAX_X = XW'(EXP_MAX);

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_sign;
    logic signed [XW-1:0]    r_exp;
    logic [FRAC_W:0]         r_frac;
    logic                    r_zero;
    logic [EXP_W+MW:0]       r_fp_out;
    logic                    r_ovf;
    logic                    r_unf;
    logic                    r_inx;
    logic                    r_out_valid;

    logic [IDX_W-1:0]        w_lod_idx;
    logic                    w_lod_zero;
    logic [IDX_W-1:0]        w_shamt;
    logic [FRAC_W-1:0]       w_norm_frac;
    logic signed [XW-1:0]    w_norm_exp;
    logic                    w_norm_zero;

    logic                    w_guard;
    logic                    w_sticky;
    logic                    w_inc;
    logic [MW:0]             w_mant_sum;
    logic signed [XW-1:0]    w_exp_rnd;
    logic [EXP_W+MW:0]       w_res_fp;
    logic                    w_res_ovf;
    logic                    w_res_unf;
    logic                    w_res_inx;

    leading_one_detect #(
        .W     (FRAC_W),
        .IDX_W (IDX_W)
    ) u_lod (
        .i_data (r_frac[FRAC_W-1:0]),
        .o_idx  (w_lod_idx),
        .o_zero (w_lod_zero)
    );

    assign w_shamt     = IDX_W'(FRAC_W - 1) - w_lod_idx;
    assign w_norm_zero = w_lod_zero && !r_frac[FRAC_W];

    // Normalize: carry-out shifts right keeping sticky, otherwise shift the leading one up to the hidden bit.
    always_comb begin
        w_norm_frac = r_frac[FRAC_W-1:0] << w_shamt;
        w_norm_exp  = r_exp - $signed({{(XW-IDX_W){1'b0}}, w_shamt});
        if (r_frac[FRAC_W]) begin
            w_norm_frac = {r_frac[FRAC_W:2], r_frac[1] | r_frac[0]};
            w_norm_exp  = r_exp + $signed(XW'(1));
        end
    end

    assign w_guard    = r_frac[1];
    assign w_sticky   = r_frac[0];
    assign w_inc      = w_guard && (w_sticky || r_frac[2]);
    assign w_mant_sum = {1'b0, r_frac[FRAC_W-2:2]} + (MW+1)'(w_inc);
    // A rounding carry leaves the mantissa field all-zero and bumps the exponent.
    assign w_exp_rnd  = r_exp + $signed({{(XW-1){1'b0}}, w_mant_sum[MW]});

    // Round-to-nearest-even result with overflow to infinity and flush-to-zero underflow.
    always_comb begin
        w_res_fp  = {r_sign, w_exp_rnd[EXP_W-1:0], w_mant_sum[MW-1:0]};
        w_res_ovf = 1'b0;
        w_res_unf = 1'b0;
        w_res_inx = w_guard | w_sticky;
        if (r_zero) begin
            w_res_fp  = '0;
            w_res_inx = 1'b0;
        end else if (!w_exp_rnd[XW-1] && (w_exp_rnd >= EXP_MAX_X)) begin
            w_res_fp  = {r_sign, {EXP_W{1'b1}}, {MW{1'b0}}};
            w_res_ovf = 1'b1;
            w_res_inx = 1'b1;
        end else if (w_exp_rnd[XW-1] || (w_exp_rnd == '0)) begin
            w_res_fp  = {r_sign, {(EXP_W+MW){1'b0}}};
            w_res_unf = 1'b1;
            w_res_inx = 1'b1;
        end
    end

    // State register; reset abandons any operand in flight.
    always_ff @(posedge CLK) begin
        if (!nRST) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next state: fixed walk through NORM and ROUND, hold DONE until the output handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_next = ST_NORM;
            ST_NORM:  w_next = ST_ROUND;
            ST_ROUND: w_next = ST_DONE;
            ST_DONE:  if (r_out_valid && out_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Datapath registers: capture, normalize, round, then present the result.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_frac      <= '0;
            r_zero      <= 1'b0;
            r_fp_out    <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_inx       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sign <= sign_in;
                        r_exp  <= $signed({{(XW-EXP_W){1'b0}}, exp_in});
                        r_frac <= frac_in;
                    end
                end
                ST_NORM: begin
                    r_frac <= {1'b0, w_norm_frac};
                    r_exp  <= w_norm_exp;
                    r_zero <= w_norm_zero;
                end
                ST_ROUND: begin
                    r_fp_out <= w_res_fp;
                    r_ovf    <= w_res_ovf;
                    r_unf    <= w_res_unf;
                    r_inx    <= w_res_inx;
                end
                ST_DONE: begin
                    r_out_valid <= !(r_out_valid && out_ready);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = nRST && (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign fp_out    = r_fp_out;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign inexact   = r_inx;

endmodule

// File: tb/tb_add_normalize_round.sv
// Directed-vector bench for add_normalize_round.
module tb_add_normalize_round;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_in = 1'b0;
    logic [7:0]  exp_in = '0;
    logic [26:0] frac_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] fp_out;
    logic        overflow, underflow, inexact;

    int checks = 0;
    int failures = 0;

    add_normalize_round dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .frac_in   (frac_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_out    (fp_out),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drives one operand, waits (bounded) for the result, then handshakes it.
    task automatic do_op(input logic s, input logic [7:0] e, input logic [26:0] f,
                         output logic [31:0] fp, output logic [2:0] fl, output int lat);
        int w = 0;
        while (!in_ready && w < 20) begin step(); w++; end
        sign_in = s; exp_in = e; frac_in = f; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin step(); lat++; end
        fp = fp_out;
        fl = {overflow, underflow, inexact};
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0; in_valid = 1'b1; frac_in = 27'h4000000; exp_in = 8'd127;
        repeat (3) step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (fp_out !== 32'h0) begin failures++; $display("FAIL reset_fp_out got=%h want=00000000", fp_out); end
        checks++; if ({overflow, underflow, inexact} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", {overflow, underflow, inexact}); end
        in_valid = 1'b0;
        nRST = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
        repeat (4) step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_no_capture got=%b want=0", out_valid); end
    endtask

    task automatic test_carry();
        logic [31:0] fp; logic [2:0] fl; int lat;
        do_op(1'b0, 8'd127, {1'b1, 26'b0}, fp, fl, lat);
        checks++; if (fp !== 32'h40000000) begin failures++; $display("FAIL carry_fp got=%h want=40000000", fp); end
        checks++; if (fl !== 3'b000) begin failures++; $display("FAIL carry_flags got=%b want=000", fl); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL carry_latency got=%0d want=3", lat); end
    endtask

    task automatic test_cancel();
        logic [31:0] fp; logic [2:0] fl; int lat;
        do_op(1'b0, 8'd127, 27'h0000004, fp, fl, lat);
        checks++; if (fp !== 32'h34000000) begin failures++; $display("FAIL cancel_fp got=%h want=34000000", fp); end
        checks++; if (fl !== 3'b000) begin failures++; $display("FAIL cancel_flags got=%b want=000", fl); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL cancel_latency got=%0d want=3", lat); end
        do_op(1'b1, 8'd127, 27'h0000004, fp, fl, lat);
        checks++; if (fp !== 32'hB4000000) begin failures++; $display("FAIL cancel_neg_fp got=%h want=b4000000", fp); end
        do_op(1'b1, 8'd127, 27'h0000000, fp, fl, lat);
        checks++; if (fp !== 32'h00000000) begin failures++; $display("FAIL zero_fp got=%h want=00000000", fp); end
        checks++; if (fl !== 3'b000) begin failures++; $display("FAIL zero_flags got=%b want=000", fl); end
    endtask

    task automatic test_ties();
        logic [31:0] fp; logic [2:0] fl; int lat;
        do_op(1'b0, 8'd127, {1'b0, 1'b1, 23'h000001, 2'b10}, fp, fl, lat);
        checks++; if (fp !== 32'h3F800002) begin failures++; $display("FAIL tie_odd_fp got=%h want=3f800002", fp); end
        checks++; if (fl !== 3'b001) begin failures++; $display("FAIL tie_odd_flags got=%b want=001", fl); end
        do_op(1'b0, 8'd127, {1'b0, 1'b1, 23'h000000, 2'b10}, fp, fl, lat);
        checks++; if (fp !== 32'h3F800000) begin failures++; $display("FAIL tie_even_fp got=%h want=3f800000", fp); end
        checks++; if (fl !== 3'b001) begin failures++; $display("FAIL tie_even_flags got=%b want=001", fl); end
        do_op(1'b0, 8'd127, {1'b0, 1'b1, 23'h7FFFFF, 2'b11}, fp, fl, lat);
        checks++; if (fp !== 32'h40000000) begin failures++; $display("FAIL round_carry_fp got=%h want=40000000", fp); end
        checks++; if (fl !== 3'b001) begin failures++; $display("FAIL round_carry_flags got=%b want=001", fl); end
    endtask

    task automatic test_range();
        logic [31:0] fp; logic [2:0] fl; int lat;
        do_op(1'b0, 8'd254, {1'b1, 26'b0}, fp, fl, lat);
        checks++; if (fp !== 32'h7F800000) begin failures++; $display("FAIL ovf_fp got=%h want=7f800000", fp); end
        checks++; if (fl !== 3'b101) begin failures++; $display("FAIL ovf_flags got=%b want=101", fl); end
        do_op(1'b1, 8'd254, {1'b1, 26'b0}, fp, fl, lat);
        checks++; if (fp !== 32'hFF800000) begin failures++; $display("FAIL ovf_neg_fp got=%h want=ff800000", fp); end
        do_op(1'b0, 8'd5, 27'h0000004, fp, fl, lat);
        checks++; if (fp !== 32'h00000000) begin failures++; $display("FAIL unf_fp got=%h want=00000000", fp); end
        checks++; if (fl !== 3'b011) begin failures++; $display("FAIL unf_flags got=%b want=011", fl); end
        do_op(1'b1, 8'd5, 27'h0000004, fp, fl, lat);
        checks++; if (fp !== 32'h80000000) begin failures++; $display("FAIL unf_neg_fp got=%h want=80000000", fp); end
    endtask

    task automatic test_backpressure();
        int lat = 0;
        sign_in = 1'b0; exp_in = 8'd127; frac_in = {1'b1, 26'b0}; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin step(); lat++; end
        checks++; if (lat !== 3) begin failures++; $display("FAIL bp_latency got=%0d want=3", lat); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if ({out_valid, fp_out} !== {1'b1, 32'h40000000}) begin failures++; $display("FAIL bp_hold_%0d got=%b/%h want=1/40000000", i, out_valid, fp_out); end
            checks++; if ({in_ready, overflow, underflow, inexact} !== 4'b0000) begin failures++; $display("FAIL bp_ready_flags_%0d got=%b want=0000", i, {in_ready, overflow, underflow, inexact}); end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL bp_release got=%b want=10", {in_ready, out_valid}); end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        out_ready = 1'b1;
        sign_in = 1'b0; exp_in = 8'd127; frac_in = 27'h0000004; in_valid = 1'b1;
        step();
        frac_in = {1'b1, 26'b0};
        while (!out_valid && lat < 20) begin step(); lat++; end
        checks++; if (lat !== 3) begin failures++; $display("FAIL b2b_a_latency got=%0d want=3", lat); end
        checks++; if (fp_out !== 32'h34000000) begin failures++; $display("FAIL b2b_a_fp got=%h want=34000000", fp_out); end
        step();
        checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL b2b_idle got=%b want=10", {in_ready, out_valid}); end
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin step(); lat++; end
        checks++; if (lat !== 3) begin failures++; $display("FAIL b2b_b_latency got=%0d want=3", lat); end
        checks++; if (fp_out !== 32'h40000000) begin failures++; $display("FAIL b2b_b_fp got=%h want=40000000", fp_out); end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic [31:0] fp; logic [2:0] fl; int lat;
        sign_in = 1'b1; exp_in = 8'd254; frac_in = {1'b1, 26'b0}; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        nRST = 1'b0;
        step();
        checks++; if ({out_valid, in_ready} !== 2'b00) begin failures++; $display("FAIL midrst_valid_ready got=%b want=00", {out_valid, in_ready}); end
        checks++; if (fp_out !== 32'h0) begin failures++; $display("FAIL midrst_fp got=%h want=00000000", fp_out); end
        nRST = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_idle got=%b want=1", in_ready); end
        repeat (4) step();
        checks++; if ({out_valid, overflow} !== 2'b00) begin failures++; $display("FAIL midrst_discard got=%b want=00", {out_valid, overflow}); end
        do_op(1'b0, 8'd127, 27'h0000004, fp, fl, lat);
        checks++; if ({fp, fl} !== {32'h34000000, 3'b000}) begin failures++; $display("FAIL midrst_fresh got=%h/%b want=34000000/000", fp, fl); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL midrst_latency got=%0d want=3", lat); end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_cancel();
        test_ties();
        test_range();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
